// File: rtl/uart_mmio_baud.sv
// Memory-mapped 8N1 UART: integer baud generator, oversampling receiver and a
// transmitter with a one-byte holding register in front of the shifter.
module uart_mmio_baud #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mm_write,
   input  logic        mm_read,
   input  logic [1:0]  mm_addr,
   input  logic [31:0] mm_wdata,
   output logic [31:0] mm_rdata,
   input  logic        serial_rx,
   output logic        serial_tx,
   output logic        clock_baud_9600,
   output logic        irq
);

   localparam int TICK_DIV = CLOCK_FREQ / (BAUD * OVERSAMPLE);
   localparam int BIT_CLKS = TICK_DIV * OVERSAMPLE;
   localparam int HALF_BIT = BIT_CLKS / 2;
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = $clog2(BIT_CLKS);
   localparam int HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
   localparam int OW = $clog2(OVERSAMPLE);

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CLKS - 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT - 1);
   localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
   localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   logic [TW-1:0] tick_cnt;
   logic [HW-1:0] baud_cnt;
   logic          os_tick;
   logic          rx_meta, rx_sync;

   rx_state_t     rx_state, rx_next;
   logic [OW-1:0] os_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    rx_shift, rx_byte;
   logic          rx_valid, overrun, frame_err;
   logic          os_clr, os_inc, bit_clr, bit_inc, shift_en, byte_done, frame_set;

   logic [7:0]    hold_data;
   logic          hold_full, tx_ready, tx_busy;
   logic [8:0]    tx_shift;
   logic [3:0]    tx_bit_idx;
   logic [BW-1:0] tx_clk_cnt;
   logic          tx_frame_end, tx_load;

   logic          wr_tx, wr_ctrl, rd_rx;
   logic [31:0]   read_val;
   logic          unused_wdata;

   assign unused_wdata = &{1'b0, mm_wdata[31:8]};
   assign os_tick      = (tick_cnt == TICK_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt        <= '0;
         baud_cnt        <= '0;
         clock_baud_9600 <= 1'b0;
      end else begin
         tick_cnt <= os_tick ? '0 : tick_cnt + TW'(1);
         if (baud_cnt == HALF_LAST) begin
            baud_cnt        <= '0;
            clock_baud_9600 <= ~clock_baud_9600;
         end else begin
            baud_cnt <= baud_cnt + HW'(1);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= serial_rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rx_state <= RX_IDLE;
      else       rx_state <= rx_next;
   end

   // Sample points are counted in oversample ticks from the detected falling edge.
   always_comb begin
      rx_next   = rx_state;
      os_clr    = 1'b0;
      os_inc    = 1'b0;
      bit_clr   = 1'b0;
      bit_inc   = 1'b0;
      shift_en  = 1'b0;
      byte_done = 1'b0;
      frame_set = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (!rx_sync) begin
               rx_next = RX_START;
               os_clr  = 1'b1;
            end
         end
         RX_START: begin
            if (os_tick) begin
               if (os_cnt == OS_MID) begin
                  os_clr  = 1'b1;
                  bit_clr = 1'b1;
                  rx_next = rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  os_inc = 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (os_tick) begin
               if (os_cnt == OS_LAST) begin
                  os_clr   = 1'b1;
                  shift_en = 1'b1;
                  if (bit_cnt == 3'd7) rx_next = RX_STOP;
                  else                 bit_inc = 1'b1;
               end else begin
                  os_inc = 1'b1;
               end
            end
         end
         RX_STOP: begin
            if (os_tick) begin
               if (os_cnt == OS_LAST) begin
                  os_clr = 1'b1;
                  if (rx_sync) begin
                     byte_done = 1'b1;
                     rx_next   = RX_IDLE;
                  end else begin
                     frame_set = 1'b1;
                     rx_next   = RX_WAIT_HIGH;
                  end
               end else begin
                  os_inc = 1'b1;
               end
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_sync) rx_next = RX_IDLE;
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         os_cnt   <= '0;
         bit_cnt  <= '0;
         rx_shift <= '0;
      end else begin
         if (os_clr)      os_cnt <= '0;
         else if (os_inc) os_cnt <= os_cnt + OW'(1);
         if (bit_clr)      bit_cnt <= '0;
         else if (bit_inc) bit_cnt <= bit_cnt + 3'd1;
         if (shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
      end
   end

   assign wr_tx   = mm_write && (mm_addr == 2'd0);
   assign wr_ctrl = mm_write && (mm_addr == 2'd3);
   assign rd_rx   = mm_read  && (mm_addr == 2'd1);

   // A completing byte takes priority over a simultaneous RXDATA read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (rd_rx) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
         if (byte_done) begin
            rx_byte  <= rx_shift;
            rx_valid <= 1'b1;
            if (rx_valid && !rd_rx) overrun <= 1'b1;
         end
         if (wr_ctrl && mm_wdata[0]) frame_err <= 1'b0;
         if (frame_set)              frame_err <= 1'b1;
      end
   end

   assign tx_ready     = ~hold_full;
   assign tx_frame_end = tx_busy && (tx_clk_cnt == BIT_LAST) && (tx_bit_idx == 4'd9);
   assign tx_load      = hold_full && (!tx_busy || tx_frame_end);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_data <= '0;
         hold_full <= 1'b0;
      end else begin
         if (tx_load) hold_full <= 1'b0;
         if (wr_tx && (!hold_full || tx_load)) begin
            hold_data <= mm_wdata[7:0];
            hold_full <= 1'b1;
         end
      end
   end

   // Reloading straight from the stop bit's last cycle keeps frames gap-free.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         serial_tx  <= 1'b1;
         tx_busy    <= 1'b0;
         tx_shift   <= '1;
         tx_bit_idx <= '0;
         tx_clk_cnt <= '0;
      end else if (tx_load) begin
         serial_tx  <= 1'b0;
         tx_busy    <= 1'b1;
         tx_shift   <= {1'b1, hold_data};
         tx_bit_idx <= '0;
         tx_clk_cnt <= '0;
      end else if (tx_busy) begin
         if (tx_clk_cnt == BIT_LAST) begin
            tx_clk_cnt <= '0;
            if (tx_bit_idx == 4'd9) begin
               tx_busy <= 1'b0;
            end else begin
               tx_bit_idx <= tx_bit_idx + 4'd1;
               serial_tx  <= tx_shift[0];
               tx_shift   <= {1'b1, tx_shift[8:1]};
            end
         end else begin
            tx_clk_cnt <= tx_clk_cnt + BW'(1);
         end
      end
   end

   always_comb begin
      read_val = '0;
      case (mm_addr)
         2'd1:    read_val = {24'b0, rx_byte};
         2'd2:    read_val = {27'b0, frame_err, overrun, tx_busy, tx_ready, rx_valid};
         default: read_val = '0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)        mm_rdata <= '0;
      else if (mm_read) mm_rdata <= read_val;
   end

   assign irq = rx_valid | tx_ready;

endmodule

// File: tb/tb_uart_mmio_baud.sv
// Directed self-checking bench for uart_mmio_baud at TICK_DIV=10, BIT_CLKS=160.
module tb_uart_mmio_baud;

   localparam int BIT_CLKS = 160;

   logic        clock = 1'b0;
   logic        reset;
   logic        mm_write, mm_read;
   logic [1:0]  mm_addr;
   logic [31:0] mm_wdata, mm_rdata;
   logic        serial_rx, serial_tx, clock_baud_9600, irq;

   int checks   = 0;
   int failures = 0;

   uart_mmio_baud #(
      .CLOCK_FREQ(1_536_000),
      .BAUD(9600),
      .OVERSAMPLE(16)
   ) dut (
      .clock(clock),
      .reset(reset),
      .mm_write(mm_write),
      .mm_read(mm_read),
      .mm_addr(mm_addr),
      .mm_wdata(mm_wdata),
      .mm_rdata(mm_rdata),
      .serial_rx(serial_rx),
      .serial_tx(serial_tx),
      .clock_baud_9600(clock_baud_9600),
      .irq(irq)
   );

   always #5 clock = ~clock;

   initial begin
      #600000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
      @(negedge clock);
      mm_write = 1'b1;
      mm_addr  = addr;
      mm_wdata = data;
      @(negedge clock);
      mm_write = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
      @(negedge clock);
      mm_read = 1'b1;
      mm_addr = addr;
      @(negedge clock);
      mm_read = 1'b0;
      data    = mm_rdata;
   endtask

   task automatic applyStimulus(input logic [7:0] rxByte);
      logic [9:0] frame;
      frame = {1'b1, rxByte, 1'b0};
      for (int i = 0; i < 10; i++) begin
         serial_rx = frame[i];
         waitClocks(BIT_CLKS);
      end
   endtask

   task automatic txPair(input logic [7:0] first, input logic [7:0] second);
      @(negedge clock);
      mm_write = 1'b1;
      mm_addr  = 2'd0;
      mm_wdata = {24'b0, first};
      @(negedge clock);
      mm_wdata = {24'b0, second};
      @(negedge clock);
      mm_write = 1'b0;
   endtask

   task automatic measureToggle(output int count);
      logic startVal;
      int n;
      startVal = clock_baud_9600;
      n = 0;
      while (clock_baud_9600 === startVal && n < 1000) begin
         @(negedge clock);
         n++;
      end
      count = n;
   endtask

   initial begin
      logic [31:0] rd;
      logic [19:0] txExpect;
      int n;

      reset     = 1'b1;
      mm_write  = 1'b0;
      mm_read   = 1'b0;
      mm_addr   = 2'd0;
      mm_wdata  = '0;
      serial_rx = 1'b1;
      waitClocks(5);
      checkOutput("reset_serial_tx", 32'(serial_tx), 32'h1);
      checkOutput("reset_clock_baud", 32'(clock_baud_9600), 32'h0);
      checkOutput("reset_rdata", mm_rdata, 32'h0);
      checkOutput("reset_irq", 32'(irq), 32'h1);
      reset = 1'b0;

      busRead(2'd2, rd);
      checkOutput("status_after_reset", rd, 32'h02);

      measureToggle(n);
      measureToggle(n);
      checkOutput("baud_half_period_a", n, 80);
      measureToggle(n);
      checkOutput("baud_half_period_b", n, 80);

      applyStimulus(8'h42);
      busRead(2'd2, rd);
      checkOutput("status_rx_valid", rd, 32'h03);
      busRead(2'd1, rd);
      checkOutput("rxdata_42", rd, 32'h42);
      busRead(2'd2, rd);
      checkOutput("status_after_rx_read", rd, 32'h02);

      applyStimulus(8'h42);
      waitClocks(BIT_CLKS);
      applyStimulus(8'hB0);
      busRead(2'd2, rd);
      checkOutput("status_overrun", rd, 32'h0B);
      busRead(2'd1, rd);
      checkOutput("rxdata_b0", rd, 32'hB0);
      busRead(2'd2, rd);
      checkOutput("status_overrun_cleared", rd, 32'h02);

      txExpect = {1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 1'b0};
      txPair(8'h55, 8'hA3);
      checkOutput("irq_holding_full", 32'(irq), 32'h0);
      waitClocks(BIT_CLKS / 2);
      for (int k = 0; k < 20; k++) begin
         checkOutput($sformatf("tx_bit%0d", k), 32'(serial_tx), 32'(txExpect[k]));
         if (k == 5)  checkOutput("tx_ready_first_frame", 32'(irq), 32'h0);
         if (k == 15) checkOutput("tx_ready_second_frame", 32'(irq), 32'h1);
         if (k < 19) waitClocks(BIT_CLKS);
      end
      waitClocks(90);
      checkOutput("tx_idle_line", 32'(serial_tx), 32'h1);
      busRead(2'd2, rd);
      checkOutput("status_tx_done", rd, 32'h02);

      serial_rx = 1'b0;
      waitClocks(10 * BIT_CLKS);
      serial_rx = 1'b1;
      waitClocks(2 * BIT_CLKS);
      busRead(2'd2, rd);
      checkOutput("status_frame_err", rd, 32'h12);
      busWrite(2'd3, 32'h1);
      busRead(2'd2, rd);
      checkOutput("status_frame_err_cleared", rd, 32'h02);

      serial_rx = 1'b0;
      waitClocks(30);
      serial_rx = 1'b1;
      waitClocks(2 * BIT_CLKS);
      busRead(2'd2, rd);
      checkOutput("status_after_glitch", rd, 32'h02);

      txPair(8'h00, 8'h00);
      waitClocks(400);
      checkOutput("tx_mid_frame_low", 32'(serial_tx), 32'h0);
      reset = 1'b1;
      #1;
      checkOutput("reset_mid_frame_tx", 32'(serial_tx), 32'h1);
      checkOutput("reset_mid_frame_irq", 32'(irq), 32'h1);
      waitClocks(3);
      reset = 1'b0;
      waitClocks(300);
      checkOutput("tx_idle_after_reset", 32'(serial_tx), 32'h1);
      busRead(2'd2, rd);
      checkOutput("status_after_mid_reset", rd, 32'h02);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
